oscill_acq_ctrl: RTL

Acquisition controller for the oscilloscope sample path. It programs the ADC clock divider's `adc_clk_sel` from the requested timebase and derives a one-cycle sample strobe from the divided clock. It runs the pre-trigger / armed / post-trigger capture sequence into a circular sample RAM, with edge triggering on the sampled ADC data. It sits between the front-panel control logic (start, timebase, trigger settings), the divider, the ADC data bus and the display-side RAM reader.

---
 rtl/oscill_acq_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/oscill_acq_ctrl.sv
// Oscilloscope acquisition controller: divider select, strobe derivation and
// pre-trigger / armed / post-trigger capture into a circular sample RAM.
module oscill_acq_ctrl #(
  parameter int DW  = 8,
  parameter int AW  = 10,
  parameter int PRE = 256
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [4:0]    timebase,
  input  logic [DW-1:0] trig_level,
  input  logic          trig_edge,
  input  logic          trig_auto,
  input  logic          rd_ack,
  input  logic          clk_adc,
  input  logic [DW-1:0] adc_data,
  output logic [4:0]    adc_clk_sel,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic [AW-1:0] trig_addr,
  output logic          trig_forced,
  output logic          busy,
  output logic          done
);

  localparam logic [AW-1:0] PRE_LAST  = AW'(PRE - 1);
  localparam logic [AW-1:0] POST_INIT = AW'((1 << AW) - PRE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_PRETRIG, S_ARMED, S_POST, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic          clk_adc_q;
  logic [4:0]    sel_q, sel_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          settle_q, settle_d;
  logic [AW-1:0] post_q, post_d;
  logic [DW-1:0] prev_q, prev_d;
  logic [AW-1:0] taddr_q, taddr_d;
  logic          forced_q, forced_d;
  logic          wen_q, wen_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [DW-1:0] wdat_q, wdat_d;

  logic stb;
  logic edge_hit;
  logic auto_hit;
  logic wr_go;

  assign stb      = clk_adc & ~clk_adc_q;
  assign edge_hit = trig_edge ? ((prev_q > trig_level) && (adc_data <= trig_level))
                              : ((prev_q < trig_level) && (adc_data >= trig_level));
  // cnt_q restarts at 0 on entering ARMED, so all-ones marks the 2^AW-th armed strobe
  assign auto_hit = trig_auto && (cnt_q == '1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = S_SETTLE;
      S_SETTLE:  if (stb && settle_q) state_d = S_PRETRIG;
      S_PRETRIG: if (stb && (cnt_q == PRE_LAST)) state_d = S_ARMED;
      S_ARMED:   if (stb && (edge_hit || auto_hit)) state_d = S_POST;
      S_POST:    if (stb && (post_q <= AW'(1))) state_d = S_DONE;
      S_DONE:    if (rd_ack) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
  end

  always_comb begin
    busy  = (state_q != S_IDLE);
    done  = (state_q == S_DONE);
    wr_go = 1'b0;
    if (stb && !abort) begin
      case (state_q)
        S_PRETRIG, S_ARMED: wr_go = 1'b1;
        S_POST:             wr_go = (post_q != '0);
        default:            wr_go = 1'b0;
      endcase
    end
  end

  always_comb begin
    sel_d    = sel_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    settle_d = settle_q;
    post_d   = post_q;
    prev_d   = prev_q;
    taddr_d  = taddr_q;
    forced_d = forced_q;
    wen_d    = wr_go;
    waddr_d  = waddr_q;
    wdat_d   = wdat_q;
    if (wr_go) begin
      waddr_d = ptr_q;
      wdat_d  = adc_data;
      prev_d  = adc_data;
      ptr_d   = ptr_q + AW'(1);
    end
    if (!abort) begin
      case (state_q)
        S_IDLE: if (start) begin
          sel_d    = timebase;
          ptr_d    = '0;
          cnt_d    = '0;
          settle_d = 1'b0;
          forced_d = 1'b0;
        end
        S_SETTLE:  if (stb) settle_d = 1'b1;
        S_PRETRIG: if (stb) cnt_d = (cnt_q == PRE_LAST) ? '0 : cnt_q + AW'(1);
        S_ARMED: if (stb) begin
          cnt_d = cnt_q + AW'(1);
          if (edge_hit || auto_hit) begin
            taddr_d  = ptr_q;
            post_d   = POST_INIT;
            forced_d = !edge_hit;
          end
        end
        S_POST:  if (stb && (post_q != '0)) post_d = post_q - AW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_adc_q <= 1'b0;
      sel_q     <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      settle_q  <= 1'b0;
      post_q    <= '0;
      prev_q    <= '0;
      taddr_q   <= '0;
      forced_q  <= 1'b0;
      wen_q     <= 1'b0;
      waddr_q   <= '0;
      wdat_q    <= '0;
    end else begin
      clk_adc_q <= clk_adc;
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      settle_q  <= settle_d;
      post_q    <= post_d;
      prev_q    <= prev_d;
      taddr_q   <= taddr_d;
      forced_q  <= forced_d;
      wen_q     <= wen_d;
      waddr_q   <= waddr_d;
      wdat_q    <= wdat_d;
    end
  end

  assign adc_clk_sel = sel_q;
  assign wr_en       = wen_q;
  assign wr_addr     = waddr_q;
  assign wr_data     = wdat_q;
  assign trig_addr   = taddr_q;
  assign trig_forced = forced_q;

endmodule
